// File: rtl/seq_shift_rotate_unit_if.sv
// seq_shift_rotate_unit_if: start/done request bus between the ALU and the shift/rotate unit
interface seq_shift_rotate_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             carry;
    logic             zero;
    modport master (output start, op, x, y, input busy, done, z, carry, zero);
    modport slave  (input start, op, x, y, output busy, done, z, carry, zero);
endinterface

// File: rtl/seq_shift_rotate_unit.sv
// seq_shift_rotate_unit: multi-cycle logarithmic shift/rotate unit, one stage per clock
module seq_shift_rotate_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic                   clock,
    input logic                   clear,
    seq_shift_rotate_unit_if.slave bus
);
    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);
    localparam logic [WIDTH-1:0] W_L = WIDTH'(WIDTH);
    localparam logic [2:0] OP_SHL = 3'd0, OP_SHR = 3'd1, OP_SHRA = 3'd2, OP_ROL = 3'd3, OP_ROR = 3'd4;

    if (2 ** SHAMT_W != WIDTH || WIDTH < 4) begin : g_bad_params
        $error("seq_shift_rotate_unit: WIDTH must be a power of two >= 4 equal to 2**SHAMT_W");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0]   work, stage, sra, rol, ror;
    logic [SHAMT_W-1:0] amt, sh, nm1;
    logic [SHAMT_W:0]   shc;
    logic [K_W-1:0]     k;
    logic [2:0]         opr;
    logic               cap_c, accept, last, sat, in_rng, rot;
    logic [WIDTH-1:0]   lsh, rsh;
    logic               nxt_c;

    assign accept   = bus.start && state != SHIFT;
    assign last     = state == SHIFT && k == K_LAST;
    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;

    // State register; clear aborts any operation in flight
    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_n;
    end

    // Next state: accept from IDLE or DONE, leave SHIFT after the last stage
    always_comb begin
        state_n = state;
        state_n = accept ? SHIFT : last ? DONE : (state == DONE) ? IDLE : state;
    end

    // Capture-time decode: saturation and shift carry depend only on x and n
    always_comb begin
        nm1    = bus.y[SHAMT_W-1:0] - SHAMT_W'(1);
        lsh    = bus.x << nm1;
        rsh    = bus.x >> nm1;
        sat    = bus.y >= W_L;
        in_rng = bus.y != '0 && !(bus.y > W_L);
        nxt_c  = (bus.op == OP_SHL)  ? (in_rng & lsh[WIDTH-1]) :
                 (bus.op == OP_SHR)  ? (in_rng & rsh[0]) :
                 (bus.op == OP_SHRA) ? (in_rng ? rsh[0] : bus.x[WIDTH-1]) : 1'b0;
    end

    // One logarithmic stage: move the working register by 2**k when amt[k] is set
    always_comb begin
        sh    = amt[k] ? (SHAMT_W'(1) << k) : '0;
        shc   = (SHAMT_W + 1)'(WIDTH) - {1'b0, sh};
        sra   = $signed(work) >>> sh;
        rol   = (work << sh) | (work >> shc);
        ror   = (work >> sh) | (work << shc);
        stage = (opr == OP_SHL) ? work << sh : (opr == OP_SHR) ? work >> sh :
                (opr == OP_SHRA) ? sra : (opr == OP_ROL) ? rol : (opr == OP_ROR) ? ror : work;
        rot   = opr == OP_ROL || opr == OP_ROR;
    end

    // Datapath: saturated shifts are folded into the captured operand/amount
    always_ff @(posedge clock) begin
        if (clear) begin
            work      <= '0;
            amt       <= '0;
            k         <= '0;
            opr       <= '0;
            cap_c     <= 1'b0;
            bus.z     <= '0;
            bus.carry <= 1'b0;
            bus.zero  <= 1'b0;
        end else if (accept) begin
            work  <= (sat && (bus.op == OP_SHL || bus.op == OP_SHR)) ? '0 : bus.x;
            amt   <= (sat && bus.op == OP_SHRA) ? '1 : bus.y[SHAMT_W-1:0];
            k     <= '0;
            opr   <= bus.op;
            cap_c <= nxt_c;
        end else if (state == SHIFT) begin
            work <= stage;
            k    <= k + K_W'(1);
            if (last) begin
                bus.z     <= stage;
                bus.zero  <= stage == '0;
                bus.carry <= rot ? (amt != '0 && (opr == OP_ROL ? stage[0] : stage[WIDTH-1])) : cap_c;
            end
        end
    end
endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
// tb_seq_shift_rotate_unit: scoreboard bench for the shift/rotate unit
module tb_seq_shift_rotate_unit;
    typedef struct {
        logic [31:0] z;
        logic        c;
        logic        zr;
        int          t;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    seq_shift_rotate_unit_if #(.WIDTH(32)) bus ();

    seq_shift_rotate_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c);
        int m;
        m = int'(b % 32);
        r = a;
        c = 1'b0;
        case (o)
            3'd0: begin
                r = (b >= 32) ? 32'h0 : a << b;
                c = (b >= 1 && b <= 32) ? a[32 - int'(b)] : 1'b0;
            end
            3'd1: begin
                r = (b >= 32) ? 32'h0 : a >> b;
                c = (b >= 1 && b <= 32) ? a[int'(b) - 1] : 1'b0;
            end
            3'd2: begin
                r = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
                c = (b == 0) ? 1'b0 : (b <= 32) ? a[int'(b) - 1] : a[31];
            end
            3'd3: begin
                for (int i = 0; i < 32; i++) r[(i + m) % 32] = a[i];
                c = (m != 0) ? r[0] : 1'b0;
            end
            3'd4: begin
                for (int i = 0; i < 32; i++) r[i] = a[(i + m) % 32];
                c = (m != 0) ? r[31] : 1'b0;
            end
            default: begin
                r = a;
                c = 1'b0;
            end
        endcase
    endfunction

    // Caller must be at a negedge with the unit able to accept
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = o;
        bus.x     = a;
        bus.y     = b;
        model(o, a, b, e.z, e.c);
        e.zr = (e.z == 32'h0);
        @(posedge clock);
        @(negedge clock);
        e.t = cyc;
        sb.push_back(e);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clock);
        check("drain", 64'(sb.size()), 64'd0);
        @(negedge clock);
    endtask

    // Output monitor: every done pulse must match the oldest outstanding request
    always @(negedge clock) begin
        if (bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("z", 64'(bus.z), 64'(e.z));
                check("carry", 64'(bus.carry), 64'(e.c));
                check("zero", 64'(bus.zero), 64'(e.zr));
                check("latency", 64'(cyc - e.t), 64'd5);
                check("busy_in_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic [31:0] ys [6];
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.x     = 32'h0;
        bus.y     = 32'h0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_z", 64'(bus.z), 64'd0);
        check("rst_carry", 64'(bus.carry), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);

        issue(3'd3, 32'h55555555, 32'd7);  wait_done();
        check("rol_aa", 64'(bus.z), 64'hAAAAAAAA);
        issue(3'd3, 32'h0000FFFF, 32'd7);  wait_done();
        check("rol_7", 64'(bus.z), 64'h007FFF80);
        issue(3'd3, 32'h0000FFFF, 32'd39); wait_done();
        check("rol_39", 64'(bus.z), 64'h007FFF80);
        issue(3'd4, 32'h00000001, 32'd1);  wait_done();
        check("ror_1", 64'({bus.carry, bus.z}), 64'h1_80000000);
        issue(3'd0, 32'h80000000, 32'd1);  wait_done();
        check("shl_out", 64'({bus.zero, bus.carry, bus.z}), 64'h3_00000000);
        issue(3'd2, 32'h80000000, 32'd40); wait_done();
        check("shra_sat", 64'({bus.carry, bus.z}), 64'h1_FFFFFFFF);
        issue(3'd1, 32'h80000000, 32'd32); wait_done();
        check("shr_32", 64'({bus.carry, bus.z}), 64'h1_00000000);
        issue(3'd6, 32'h12345678, 32'd9);  wait_done();
        issue(3'd0, 32'hF000000F, 32'd0);  wait_done();

        // Starts while busy are ignored: one pulse only
        snap = done_cnt;
        issue(3'd1, 32'hDEADBEEF, 32'd4);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.x     = 32'hFFFFFFFF;
        bus.y     = 32'd3;
        for (int i = 0; i < 10 && bus.busy; i++) @(negedge clock);
        bus.start = 1'b0;
        wait_done();
        repeat (6) @(negedge clock);
        check("busy_ignore_pulses", 64'(done_cnt - snap), 64'd1);

        // Back-to-back issue in the DONE cycle
        issue(3'd3, 32'h80000001, 32'd1);
        for (int i = 0; i < 10 && !bus.done; i++) @(negedge clock);
        check("b2b_done_seen", 64'(bus.done), 64'd1);
        issue(3'd4, 32'h80000001, 32'd1);
        wait_done();

        // Clear during the third shift cycle discards the operation
        bus.start = 1'b1;
        bus.op    = 3'd3;
        bus.x     = 32'h0000F00D;
        bus.y     = 32'd5;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        snap = done_cnt;
        check("clr_busy", 64'(bus.busy), 64'd0);
        check("clr_zcz", 64'({bus.zero, bus.carry, bus.z}), 64'd0);
        repeat (8) @(negedge clock);
        check("clr_no_done", 64'(done_cnt - snap), 64'd0);

        // Clear and start on the same edge: stays idle
        issue(3'd1, 32'hFFFF0000, 32'd3); wait_done();
        clear     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd0;
        @(negedge clock);
        check("clr_start_busy", 64'(bus.busy), 64'd0);
        clear     = 1'b0;
        bus.start = 1'b0;
        snap = done_cnt;
        repeat (8) @(negedge clock);
        check("clr_start_no_done", 64'(done_cnt - snap), 64'd0);

        // Random operations across the amount boundaries
        for (int i = 0; i < 12; i++) begin
            ys[0] = 32'd0;
            ys[1] = 32'd1;
            ys[2] = 32'd31;
            ys[3] = 32'd32;
            ys[4] = 32'd33;
            ys[5] = $urandom;
            issue(3'($urandom_range(0, 7)), $urandom, ys[$urandom_range(0, 5)]);
            wait_done();
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
